pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the single-cycle core. It replaces the fixed 32-bit PC register with a configurable block that has:
- a configurable width, reset vector and sequential step;
- prioritised redirects: trap, return, then branch/jump;
- a stall input;
- a small circular return-address stack (RAS).

It sits between the next-PC selection in the control path and the instruction-memory address port.

## Interface
Parameters:
- PC_W, 32, PC and address width in bits
- STEP, 4, sequential increment; must be a power of two ≥1 (STEP=1 for word-indexed test memories)
- RESET_VEC, 0, PC value while reset is asserted and after it is released
- RAS_DEPTH, 4, return-address-stack entries; must be a power of two ≥2

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- pc_write  in  1  1 = PC may advance; 0 = stall (trap still wins)
- br_taken  in  1  branch/jump redirect request
- br_target  in  PC_W  redirect target
- call  in  1  push pc_plus onto RAS; only acts with br_taken
- ret  in  1  return: redirect to RAS top and pop
- trap_req  in  1  trap redirect
- trap_vec  in  PC_W  trap handler address
- pc_out  out  PC_W  current PC (registered)
- pc_plus  out  PC_W  pc_out + STEP (combinational, mod 2^PC_W)
- ras_top  out  PC_W  current RAS top entry (0 when empty)
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_underflow  out  1  one-cycle pulse: ret accepted with RAS empty
- misalign  out  1  one-cycle pulse: misaligned redirect was suppressed (see Configuration)

## Operation
State:
- pc register;
- RAS array of RAS_DEPTH×PC_W;
- top pointer, log2(RAS_DEPTH) bits, wraps;
- count, 0..RAS_DEPTH.

Each rising edge, the first matching case in this priority list applies:
1. trap_req=1: pc ← trap_vec, regardless of pc_write. RAS is flushed (count=0). call/ret are ignored.
2. pc_write=0: pc holds and RAS holds. All other requests are dropped; the requester must hold them.
3. ret=1 and count>0: pc ← ras_top; pop (top−1, count−1). br_taken and call are ignored.
4. ret=1 and count=0: ras_underflow pulses. The edge then falls through to case 5 or 6.
5. br_taken=1: pc ← br_target. If call=1, also push pc_plus (top+1, write entry). When full, the push overwrites the oldest entry and count stays at RAS_DEPTH.
6. Otherwise: pc ← pc_plus.

Additional rules:
- call without br_taken is ignored.
- Arithmetic is unsigned, modulo 2^PC_W. pc_plus wraps from 2^PC_W−STEP to 0.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH).
- ras_top is combinational from the array at top, forced to 0 when empty.

## Timing
- All state updates on posedge clk. Redirects take effect in pc_out one cycle after the request edge; there are no bubbles in the block.
- Asserting rst_n low immediately forces:
  - pc_out = RESET_VEC;
  - count = 0, top = 0, all RAS entries = 0;
  - ras_underflow = 0, misalign = 0.
- Reset mid-operation discards any pending push or pop.
- The first edge after rst_n deasserts performs a normal update from RESET_VEC.
- pc_plus, ras_top, ras_empty and ras_full settle combinationally in the same cycle.
- ras_underflow and misalign are registered: high for exactly the cycle after the offending edge.

## Configuration
- PC_MISALIGN_CHK_EN defined:
  - Applies when STEP>1. A br_target (case 5) or ras_top (case 3) target is misaligned if its low log2(STEP) bits are nonzero.
  - A misaligned target is not taken: pc holds and misalign pulses.
  - For case 3, the pop still occurs.
  - For case 5, the push does not occur.
- PC_MISALIGN_CHK_EN undefined:
  - misalign is tied 0 and targets are taken unmodified.
  - trap_vec is never checked in either build.

## Test plan
- Reset and sequential: STEP=4, RESET_VEC=0x100. Hold rst_n low, then release → pc_out is 0x100, 0x104, 0x108 on successive edges. Drop rst_n mid-run → pc_out is 0x100 immediately.
- Stall, trap and wrap:
  - pc_write=0 for 3 edges → pc_out constant.
  - trap_req=1 with pc_write=0, trap_vec=0x40 → pc_out=0x40 next cycle, ras_empty=1.
  - pc_out=0xFFFFFFFC, then one sequential edge → pc_out=0.
- Call/return: at pc=0x200, br_taken=1, call=1, br_target=0x800 → pc_out=0x800, ras_top=0x204. Then ret=1 → pc_out=0x204, ras_empty=1.
- RAS overflow and underflow:
  - RAS_DEPTH=4: five calls with return addresses A1..A5 → ras_full=1. Four rets return A5, A4, A3, A2, then ras_empty=1.
  - A sixth ret → ras_underflow pulses and pc advances by STEP.
- Priority: trap_req, ret and br_taken all asserted with RAS non-empty → pc=trap_vec, RAS flushed. ret and br_taken together → pc=ras_top.
- PC_MISALIGN_CHK_EN defined, STEP=4: br_taken with br_target=0x302 → pc holds and misalign=1 for one cycle. Without the macro → pc_out=0x302.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program counter with prioritised redirects (trap > return > branch/jump),
//   stall input and a small circular return-address stack (RAS).
// Latency: redirects appear on pc_out one cycle after the request edge; no bubbles.
// Backpressure: pc_write=0 holds PC and RAS and drops all requests except a trap.
// Optional feature macro: PC_MISALIGN_CHK_EN suppresses misaligned branch/return targets.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   pc_write            1 = PC may advance, 0 = stall
//   br_taken/br_target  branch/jump redirect request and target
//   call                push pc_plus onto the RAS (only together with br_taken)
//   ret                 redirect to the RAS top and pop
//   trap_req/trap_vec   trap redirect and handler address
//   pc_out, pc_plus     registered PC and its sequential successor
//   ras_top, ras_empty, ras_full    RAS status
//   ras_underflow, misalign         one-cycle registered event pulses
module pc_unit #(
  parameter int unsigned            PC_W      = 32,
  parameter int unsigned            STEP      = 4,
  parameter logic [PC_W-1:0]        RESET_VEC = '0,
  parameter int unsigned            RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  input  logic            call,
  input  logic            ret,
  input  logic            trap_req,
  input  logic [PC_W-1:0] trap_vec,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_plus,
  output logic [PC_W-1:0] ras_top,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_underflow,
  output logic            misalign
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RAS_DEPTH);

  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  ras_q [RAS_DEPTH];
  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             uf_q, uf_d;
  logic             push;
  logic             mis_d;

`ifdef PC_MISALIGN_CHK_EN
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(STEP - 1);

  // With STEP=1 the mask is zero, so nothing is ever flagged.
  function automatic logic is_misaligned(input logic [PC_W-1:0] tgt);
    return (tgt & ALIGN_MASK) != '0;
  endfunction
`endif

  assign pc_out    = pc_q;
  assign pc_plus   = pc_q + PC_W'(STEP);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_MAX);
  assign ras_top   = ras_empty ? '0 : ras_q[top_q];
  assign ras_underflow = uf_q;

  always_comb begin
    pc_d  = pc_q;
    top_d = top_q;
    cnt_d = cnt_q;
    uf_d  = 1'b0;
    mis_d = 1'b0;
    push  = 1'b0;

    if (trap_req) begin
      // Trap wins over stall; the RAS is flushed by clearing the count only.
      pc_d  = trap_vec;
      cnt_d = '0;
    end else if (!pc_write) begin
      // Stall: everything holds, requesters must re-present.
    end else if (ret && !ras_empty) begin
      // The pop happens even when the target itself is rejected.
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
`ifdef PC_MISALIGN_CHK_EN
      if (is_misaligned(ras_top)) mis_d = 1'b1;
      else                        pc_d  = ras_top;
`else
      pc_d = ras_top;
`endif
    end else begin
      // A return on an empty RAS is flagged, then the edge behaves as if no return was asked.
      uf_d = ret;
      if (br_taken) begin
`ifdef PC_MISALIGN_CHK_EN
        if (is_misaligned(br_target)) begin
          mis_d = 1'b1;
        end else begin
          pc_d = br_target;
          push = call;
        end
`else
        pc_d = br_target;
        push = call;
`endif
        if (push) begin
          // When full, the new entry lands on the oldest slot and the count saturates.
          top_d = top_q + 1'b1;
          if (!ras_full) cnt_d = cnt_q + 1'b1;
        end
      end else begin
        pc_d = pc_plus;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q  <= RESET_VEC;
      top_q <= '0;
      cnt_q <= '0;
      uf_q  <= 1'b0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      uf_q  <= uf_d;
      if (push) ras_q[top_d] <= pc_plus;
    end
  end

`ifdef PC_MISALIGN_CHK_EN
  logic mis_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end

  assign misalign = mis_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed-vector bench for pc_unit (STEP=4, RESET_VEC=0x100, RAS_DEPTH=4).
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
// Every expectation is a hand-computed constant.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_write;
  logic        br_taken;
  logic [31:0] br_target;
  logic        call;
  logic        ret;
  logic        trap_req;
  logic [31:0] trap_vec;
  logic [31:0] pc_out;
  logic [31:0] pc_plus;
  logic [31:0] ras_top;
  logic        ras_empty;
  logic        ras_full;
  logic        ras_underflow;
  logic        misalign;

  int n_total = 0;
  int n_pass  = 0;

  pc_unit #(
    .PC_W(32), .STEP(4), .RESET_VEC(32'h100), .RAS_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pc_write(pc_write),
    .br_taken(br_taken), .br_target(br_target), .call(call), .ret(ret),
    .trap_req(trap_req), .trap_vec(trap_vec),
    .pc_out(pc_out), .pc_plus(pc_plus), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_underflow(ras_underflow), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pc_write = 1'b1; br_taken = 1'b0; br_target = '0; call = 1'b0;
    ret = 1'b0; trap_req = 1'b0; trap_vec = '0;
  endtask

  task automatic do_call(input logic [31:0] tgt);
    idle(); br_taken = 1'b1; call = 1'b1; br_target = tgt;
    tick();
    idle();
  endtask

  task automatic do_ret();
    idle(); ret = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    // Reset state
    tick(); tick();
    check("rst_pc", pc_out, 32'h100);
    check("rst_plus", pc_plus, 32'h104);
    check("rst_empty", {31'b0, ras_empty}, 32'd1);
    check("rst_full", {31'b0, ras_full}, 32'd0);
    check("rst_top", ras_top, 32'h0);
    check("rst_uf", {31'b0, ras_underflow}, 32'd0);
    check("rst_mis", {31'b0, misalign}, 32'd0);

    // Release and run sequentially
    rst_n = 1'b1;
    #1 check("rel_pc", pc_out, 32'h100);
    tick(); check("seq1", pc_out, 32'h104);
    tick(); check("seq2", pc_out, 32'h108);

    // Reset mid-run is immediate
    rst_n = 1'b0;
    #1 check("midrst_pc", pc_out, 32'h100);
    tick();
    rst_n = 1'b1;

    // Stall for 3 edges
    pc_write = 1'b0;
    tick(); tick(); tick();
    check("stall_pc", pc_out, 32'h100);

    // Trap overrides stall
    trap_req = 1'b1; trap_vec = 32'h40;
    tick(); idle();
    check("trap_stall_pc", pc_out, 32'h40);
    check("trap_stall_empty", {31'b0, ras_empty}, 32'd1);

    // Wrap at the top of the address space
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    tick(); idle();
    check("wrap_pre", pc_out, 32'hFFFF_FFFC);
    check("wrap_plus", pc_plus, 32'h0);
    tick();
    check("wrap_pc", pc_out, 32'h0);

    // Call / return
    br_taken = 1'b1; br_target = 32'h200;
    tick(); idle();
    check("br_pc", pc_out, 32'h200);
    do_call(32'h800);
    check("call_pc", pc_out, 32'h800);
    check("call_top", ras_top, 32'h204);
    check("call_empty", {31'b0, ras_empty}, 32'd0);
    do_ret();
    check("ret_pc", pc_out, 32'h204);
    check("ret_empty", {31'b0, ras_empty}, 32'd1);

    // Overflow: five calls, A1=0x208 .. A5=0x4004
    do_call(32'h1000);
    do_call(32'h2000);
    do_call(32'h3000);
    do_call(32'h4000);
    check("full4", {31'b0, ras_full}, 32'd1);
    do_call(32'h5000);
    check("full5", {31'b0, ras_full}, 32'd1);
    check("ovf_top", ras_top, 32'h4004);
    do_ret(); check("pop_a5", pc_out, 32'h4004);
    do_ret(); check("pop_a4", pc_out, 32'h3004);
    do_ret(); check("pop_a3", pc_out, 32'h2004);
    do_ret(); check("pop_a2", pc_out, 32'h1004);
    check("pop_empty", {31'b0, ras_empty}, 32'd1);

    // Underflow: ret on empty falls through to a sequential step
    do_ret();
    check("uf_pulse", {31'b0, ras_underflow}, 32'd1);
    check("uf_pc", pc_out, 32'h1008);
    tick();
    check("uf_clear", {31'b0, ras_underflow}, 32'd0);
    check("uf_next_pc", pc_out, 32'h100C);

    // Priority: trap > ret > branch
    do_call(32'h6000);
    check("pri_top", ras_top, 32'h1010);
    trap_req = 1'b1; trap_vec = 32'h40; ret = 1'b1; br_taken = 1'b1; br_target = 32'h7000;
    tick(); idle();
    check("pri_trap_pc", pc_out, 32'h40);
    check("pri_trap_empty", {31'b0, ras_empty}, 32'd1);
    check("pri_trap_top", ras_top, 32'h0);
    do_call(32'h6000);
    ret = 1'b1; br_taken = 1'b1; br_target = 32'h7000;
    tick(); idle();
    check("pri_ret_pc", pc_out, 32'h44);
    check("pri_ret_empty", {31'b0, ras_empty}, 32'd1);

    // call without br_taken is ignored
    call = 1'b1;
    tick(); idle();
    check("call_only_pc", pc_out, 32'h48);
    check("call_only_empty", {31'b0, ras_empty}, 32'd1);

    // Misaligned branch target
    br_taken = 1'b1; br_target = 32'h302;
    tick(); idle();
`ifdef PC_MISALIGN_CHK_EN
    check("mis_pc", pc_out, 32'h48);
    check("mis_pulse", {31'b0, misalign}, 32'd1);
    tick();
    check("mis_clear", {31'b0, misalign}, 32'd0);
    check("mis_next_pc", pc_out, 32'h4C);
`else
    check("mis_pc", pc_out, 32'h302);
    check("mis_pulse", {31'b0, misalign}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
